cmp_stream_tracker: RTL



---
 rtl/cmp_stream_tracker.sv | 92 +++++++++
 1 files changed

// File: rtl/cmp_stream_tracker.sv
// cmp_stream_tracker: per-frame trend/max/min/rise/fall tracker on a valid/ready sample stream; CMP_SIGNED_EN selects signed compare
module cmp_stream_tracker #(
  parameter int DW = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [2:0]       trend,
  output logic             trend_valid,
  output logic [DW-1:0]    max_val,
  output logic [DW-1:0]    min_val,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             busy,
  output logic             done,
  input  logic             res_ack
);
  typedef enum logic [1:0] {IDLE, FIRST, RUN, REPORT} state_t;
  // Flipping the sign bit turns a two's-complement order into an unsigned one
`ifdef CMP_SIGNED_EN
  localparam logic [DW-1:0] SB = {1'b1, {(DW-1){1'b0}}};
`else
  localparam logic [DW-1:0] SB = '0;
`endif
  state_t state, state_nx;
  logic [DW-1:0] prev;
  logic [CNT_W-1:0] cnt;
  logic acc, gt, lt, gt_max, lt_min;
  assign acc = in_valid && in_ready;
  assign gt = (in_data ^ SB) > (prev ^ SB);
  assign lt = (in_data ^ SB) < (prev ^ SB);
  assign gt_max = (in_data ^ SB) > (max_val ^ SB);
  assign lt_min = (in_data ^ SB) < (min_val ^ SB);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FIRST : IDLE;
      FIRST:   state_nx = acc ? (FRAME_LEN == 1 ? REPORT : RUN) : FIRST;
      RUN:     state_nx = (acc && cnt == CNT_W'(FRAME_LEN - 1)) ? REPORT : RUN;
      default: state_nx = res_ack ? IDLE : REPORT;
    endcase
    in_ready = state == FIRST || state == RUN;
    busy = in_ready;
    done = state == REPORT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev <= '0;
      cnt <= '0;
      trend <= '0;
      trend_valid <= 1'b0;
      max_val <= '0;
      min_val <= '0;
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      state <= state_nx;
      trend_valid <= 1'b0;
      if (state == IDLE && start) begin
        prev <= '0;
        cnt <= '0;
        trend <= '0;
        max_val <= '0;
        min_val <= '0;
        rise_cnt <= '0;
        fall_cnt <= '0;
      end
      if (acc && state == FIRST) begin
        max_val <= in_data;
        min_val <= in_data;
        prev <= in_data;
        cnt <= CNT_W'(1);
      end
      if (acc && state == RUN) begin
        trend <= {gt, lt, !gt && !lt};
        trend_valid <= 1'b1;
        if (gt_max) max_val <= in_data;
        if (lt_min) min_val <= in_data;
        rise_cnt <= rise_cnt + CNT_W'(gt);
        fall_cnt <= fall_cnt + CNT_W'(lt);
        prev <= in_data;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule
